// File: rtl/qsys_nios2_ddr3_onchip_memory_dp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : qsys_nios2_ddr3_onchip_memory_dp                             |
// | Description : True dual-port on-chip RAM with two Avalon-MM slaves,        |
// |               byte-lane writes, deterministic write collision handling     |
// |               (s1 wins shared lanes), out-of-range protection, pipelined   |
// |               readdatavalid and an optional post-reset zero-fill.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module qsys_nios2_ddr3_onchip_memory_dp #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 15,
    parameter int DEPTH      = 32000,
    parameter int OUTREG     = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,
    // port s1 (Nios II data master)
    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    output logic                  s1_waitrequest,
    // port s2 (DMA / debug)
    input  logic [ADDR_W-1:0]     s2_address,
    input  logic                  s2_chipselect,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0]     s2_writedata,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  s2_waitrequest
);

    localparam int c_be_w  = DATA_W / 8;
    localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Word count widened by one bit so DEPTH == 2^ADDR_W is representable.
    localparam logic [ADDR_W:0]    c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(DEPTH - 1);

    localparam logic [1:0] c_st_reset = 2'd0;
    localparam logic [1:0] c_st_clear = 2'd1;
    localparam logic [1:0] c_st_ready = 2'd2;

    logic [DATA_W-1:0]  r_mem [0:DEPTH-1];
    logic [1:0]         r_state;
    logic [c_idx_w-1:0] r_clr_cnt;
    logic               w_wait;

    // Ports folded into two-entry arrays so both share one generate body.
    logic [ADDR_W-1:0]  w_addr   [2];
    logic [c_idx_w-1:0] w_idx    [2];
    logic               w_cs     [2];
    logic               w_rd     [2];
    logic               w_wr     [2];
    logic [c_be_w-1:0]  w_be     [2];
    logic [DATA_W-1:0]  w_wd     [2];
    logic               w_mem_wr [2];
    logic [DATA_W-1:0]  w_rdata  [2];
    logic               w_rvalid [2];

    assign w_addr[0] = s1_address;
    assign w_cs[0]   = s1_chipselect;
    assign w_rd[0]   = s1_read;
    assign w_wr[0]   = s1_write;
    assign w_be[0]   = s1_byteenable;
    assign w_wd[0]   = s1_writedata;

    assign w_addr[1] = s2_address;
    assign w_cs[1]   = s2_chipselect;
    assign w_rd[1]   = s2_read;
    assign w_wr[1]   = s2_write;
    assign w_be[1]   = s2_byteenable;
    assign w_wd[1]   = s2_writedata;

    // Both ports stall until the clear has finished, and whenever the CPU
    // requests a reset; reset_req acts combinationally.
    assign w_wait = (r_state != c_st_ready) | reset_req;

    assign s1_waitrequest   = w_wait;
    assign s2_waitrequest   = w_wait;
    assign s1_readdata      = w_rdata[0];
    assign s1_readdatavalid = w_rvalid[0];
    assign s2_readdata      = w_rdata[1];
    assign s2_readdatavalid = w_rvalid[1];

    // Reset / zero-fill / ready sequencer with the clear address counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_reset;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                c_st_reset: begin
                    r_clr_cnt <= '0;
                    r_state   <= (INIT_CLEAR != 0) ? c_st_clear : c_st_ready;
                end
                c_st_clear: begin
                    if (r_clr_cnt == c_last) begin
                        r_state <= c_st_ready;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + c_idx_w'(1);
                    end
                end
                c_st_ready: begin
                    r_state <= c_st_ready;
                end
                default: begin
                    r_state <= c_st_reset;
                end
            endcase
        end
    end

    // Memory array writes: zero-fill while clearing, otherwise byte-lane
    // writes. s2 is applied first so s1 overrides any lane both ports enable
    // at the same address.
    always_ff @(posedge clk) begin
        if (r_state == c_st_clear) begin
            r_mem[r_clr_cnt] <= '0;
        end else begin
            for (int p = 1; p >= 0; p--) begin
                for (int b = 0; b < c_be_w; b++) begin
                    if (w_mem_wr[p] && w_be[p][b]) begin
                        r_mem[w_idx[p]][b*8 +: 8] <= w_wd[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic              w_cmd;
        logic              w_in_range;
        logic              w_acc_rd;
        logic              r_v1;
        logic [DATA_W-1:0] r_d1;

        assign w_cmd      = w_cs[gi] & (w_rd[gi] | w_wr[gi]) & ~w_wait;
        assign w_in_range = ({1'b0, w_addr[gi]} < c_depth);
        // A simultaneous read and write is treated as a write only.
        assign w_acc_rd     = w_cmd & ~w_wr[gi];
        assign w_mem_wr[gi] = w_cmd & w_wr[gi] & w_in_range;
        assign w_idx[gi]    = w_addr[gi][c_idx_w-1:0];

        // First read stage: array read (old data on read-during-write),
        // out-of-range reads return zero, data holds between reads.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_v1 <= 1'b0;
                r_d1 <= '0;
            end else begin
                r_v1 <= w_acc_rd;
                if (w_acc_rd) begin
                    r_d1 <= w_in_range ? r_mem[w_idx[gi]] : '0;
                end
            end
        end

        if (OUTREG != 0) begin : g_outreg
            logic              r_v2;
            logic [DATA_W-1:0] r_d2;

            // Optional output register stage; data only moves with valid.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= r_d1;
                    end
                end
            end

            assign w_rvalid[gi] = r_v2;
            assign w_rdata[gi]  = r_d2;
        end else begin : g_direct
            assign w_rvalid[gi] = r_v1;
            assign w_rdata[gi]  = r_d1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qsys_nios2_ddr3_onchip_memory_dp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_qsys_nios2_ddr3_onchip_memory_dp                          |
// | Description : Self-checking bench: three instances (latency 1, latency 2,  |
// |               no zero-fill) against a cycle-indexed behavioural model,     |
// |               plus table vectors and directed corner-case sequences.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_qsys_nios2_ddr3_onchip_memory_dp;

    localparam int AW   = 5;
    localparam int DEP  = 16;
    localparam int MAXC = 4096;
    localparam int INF  = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          reset_req;
    logic [AW-1:0] addr [2];
    logic          cs   [2];
    logic          rd   [2];
    logic          wr   [2];
    logic [3:0]    be   [2];
    logic [31:0]   wd   [2];

    logic [31:0]   rdata  [3][2];
    logic          rvalid [3][2];
    logic          wreq   [3][2];

    // Instance 0: latency 1, instance 1: latency 2, instance 2: no zero-fill.
    for (genvar k = 0; k < 3; k++) begin : g_dut
        qsys_nios2_ddr3_onchip_memory_dp #(
            .DATA_W     (32),
            .ADDR_W     (AW),
            .DEPTH      (DEP),
            .OUTREG     ((k == 1) ? 1 : 0),
            .INIT_CLEAR ((k == 2) ? 0 : 1)
        ) u_dut (
            .clk              (clk),
            .reset            (reset),
            .reset_req        (reset_req),
            .s1_address       (addr[0]),
            .s1_chipselect    (cs[0]),
            .s1_read          (rd[0]),
            .s1_write         (wr[0]),
            .s1_byteenable    (be[0]),
            .s1_writedata     (wd[0]),
            .s1_readdata      (rdata[k][0]),
            .s1_readdatavalid (rvalid[k][0]),
            .s1_waitrequest   (wreq[k][0]),
            .s2_address       (addr[1]),
            .s2_chipselect    (cs[1]),
            .s2_read          (rd[1]),
            .s2_write         (wr[1]),
            .s2_byteenable    (be[1]),
            .s2_writedata     (wd[1]),
            .s2_readdata      (rdata[k][1]),
            .s2_readdatavalid (rvalid[k][1]),
            .s2_waitrequest   (wreq[k][1])
        );
    end

    // Behavioural model: memory image, returns scheduled by cycle number,
    // and the cycle from which each instance accepts commands.
    logic [31:0] mmem [3][DEP];
    bit          ev   [3][2][MAXC];
    logic [31:0] ed   [3][2][MAXC];
    logic [31:0] last [3][2];
    int          ready_at [3];
    bit          prev_reset;
    int          cyc;
    int          checks;
    int          errors;

    typedef struct {
        bit          w1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [3:0]  b1;
        bit          w2;
        logic [4:0]  a2;
        logic [31:0] d2;
        logic [3:0]  b2;
        logic [4:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input int p, input bit r, input bit w, input int a,
                         input logic [31:0] d, input logic [3:0] b);
        cs[p]   = r | w;
        rd[p]   = r;
        wr[p]   = w;
        addr[p] = AW'(a);
        wd[p]   = d;
        be[p]   = b;
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 0, 32'h0, 4'h0);
    endtask

    // One clock cycle: compare this cycle's outputs with the model, advance
    // the model with this cycle's inputs, then move to the next negedge.
    task automatic tick();
        bit mw;
        bit acc;
        int a;
        int lat;
        #1;
        for (int k = 0; k < 3; k++) begin
            mw = (cyc < ready_at[k]) || reset_req;
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("dut%0d_s%0d_waitrequest", k, p + 1), 32'(wreq[k][p]), 32'(mw));
                chk($sformatf("dut%0d_s%0d_readdatavalid", k, p + 1), 32'(rvalid[k][p]), 32'(ev[k][p][cyc]));
                if (ev[k][p][cyc]) last[k][p] = ed[k][p][cyc];
                if (k != 2) chk($sformatf("dut%0d_s%0d_readdata", k, p + 1), rdata[k][p], last[k][p]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            mw  = (cyc < ready_at[k]) || reset_req;
            lat = (k == 1) ? 2 : 1;
            for (int p = 0; p < 2; p++) begin
                acc = cs[p] && (rd[p] || wr[p]) && !mw;
                a   = int'(addr[p]);
                if (acc && !wr[p] && !reset) begin
                    ev[k][p][cyc + lat] = 1'b1;
                    ed[k][p][cyc + lat] = (a < DEP) ? mmem[k][a] : 32'h0;
                end
            end
            for (int p = 1; p >= 0; p--) begin
                acc = cs[p] && wr[p] && !mw;
                a   = int'(addr[p]);
                if (acc && a < DEP) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[p][b]) mmem[k][a][b*8 +: 8] = wd[p][b*8 +: 8];
                    end
                end
            end
            if (reset) begin
                ready_at[k] = INF;
                for (int p = 0; p < 2; p++) begin
                    ev[k][p][cyc + 1] = 1'b0;
                    ev[k][p][cyc + 2] = 1'b0;
                    last[k][p] = 32'h0;
                end
            end else if (prev_reset) begin
                ready_at[k] = cyc + 1 + ((k != 2) ? DEP : 0);
                if (k != 2) begin
                    for (int i = 0; i < DEP; i++) mmem[k][i] = 32'h0;
                end
            end
        end
        prev_reset = reset;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (cyc + 3 >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    // Count cycles of waitrequest on instance 0 after the release cycle.
    task automatic count_wait(input string nm);
        int n;
        n = 0;
        while (wreq[0][0] && n < 40) begin
            tick();
            n++;
        end
        chk(nm, 32'(n), 32'(DEP));
    endtask

    initial begin
        int cnt0;
        int cnt1;
        int run1;
        int max1;

        checks     = 0;
        errors     = 0;
        cyc        = 0;
        prev_reset = 1'b1;
        reset      = 1'b1;
        reset_req  = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            ready_at[k] = INF;
            last[k][0]  = 32'h0;
            last[k][1]  = 32'h0;
            for (int i = 0; i < DEP; i++) mmem[k][i] = 32'h0;
        end

        tbl[0]  = '{1'b1, 5'd9,  32'h0BADC0DE, 4'hF, 1'b0, 5'd0,  32'h0,        4'h0, 5'd9,  32'h0BADC0DE};
        tbl[1]  = '{1'b1, 5'd3,  32'h11223344, 4'h3, 1'b1, 5'd3,  32'hAABBCCDD, 4'hE, 5'd3,  32'hAABB3344};
        tbl[2]  = '{1'b1, 5'd20, 32'hFFFFFFFF, 4'hF, 1'b0, 5'd0,  32'h0,        4'h0, 5'd20, 32'h00000000};
        tbl[3]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd6,  32'h12345678, 4'h0, 5'd6,  32'h00000000};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd6,  32'hCAFEF00D, 4'h9, 5'd6,  32'hCA00000D};
        tbl[5]  = '{1'b1, 5'd15, 32'h5A5A5A5A, 4'hF, 1'b1, 5'd0,  32'h0000FFFF, 4'h3, 5'd15, 32'h5A5A5A5A};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,        4'h0, 5'd0,  32'h0000FFFF};
        tbl[7]  = '{1'b1, 5'd7,  32'h00000001, 4'hF, 1'b0, 5'd0,  32'h0,        4'h0, 5'd7,  32'h00000001};
        tbl[8]  = '{1'b1, 5'd2,  32'h11111111, 4'hF, 1'b1, 5'd2,  32'h22222222, 4'hF, 5'd2,  32'h11111111};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd16, 32'hFFFFFFFF, 4'hF, 5'd16, 32'h00000000};
        tbl[10] = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,        4'h0, 5'd4,  32'h00000000};
        tbl[11] = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,        4'h0, 5'd0,  32'h0000FFFF};

        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset values, then clear duration after release.
        repeat (3) tick();
        reset = 1'b0;
        tick();
        count_wait("clear_wait_cycles");

        // Every word reads back as zero after the fill.
        for (int a = 0; a < DEP; a++) begin
            drive(0, 1'b1, 1'b0, a, 32'h0, 4'h0);
            tick();
        end
        idle();
        repeat (3) tick();

        // Table vectors: write cycle, readback on s1, compare held data.
        for (int i = 0; i < 12; i++) begin
            drive(0, 1'b0, tbl[i].w1, int'(tbl[i].a1), tbl[i].d1, tbl[i].b1);
            drive(1, 1'b0, tbl[i].w2, int'(tbl[i].a2), tbl[i].d2, tbl[i].b2);
            tick();
            idle();
            drive(0, 1'b1, 1'b0, int'(tbl[i].ra), 32'h0, 4'h0);
            tick();
            idle();
            repeat (3) tick();
            chk($sformatf("vec%0d_lat1", i), rdata[0][0], tbl[i].exp);
            chk($sformatf("vec%0d_lat2", i), rdata[1][0], tbl[i].exp);
        end

        // Latency: s1 write then s2 read of the same word next cycle.
        drive(0, 1'b0, 1'b1, 5, 32'hDEADBEEF, 4'hF);
        tick();
        idle();
        drive(1, 1'b1, 1'b0, 5, 32'h0, 4'h0);
        tick();
        idle();
        #1;
        chk("lat1_valid_t1", 32'(rvalid[0][1]), 32'd1);
        chk("lat1_data_t1", rdata[0][1], 32'hDEADBEEF);
        chk("lat2_valid_t1", 32'(rvalid[1][1]), 32'd0);
        tick();
        chk("lat2_valid_t2", 32'(rvalid[1][1]), 32'd1);
        chk("lat2_data_t2", rdata[1][1], 32'hDEADBEEF);
        chk("lat1_valid_t2", 32'(rvalid[0][1]), 32'd0);
        tick();

        // Back-to-back reads of 0..7 on s2.
        cnt0 = 0;
        cnt1 = 0;
        run1 = 0;
        max1 = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) drive(1, 1'b1, 1'b0, i, 32'h0, 4'h0);
            else idle();
            tick();
            if (rvalid[0][1]) cnt0++;
            if (rvalid[1][1]) begin
                cnt1++;
                run1++;
                if (run1 > max1) max1 = run1;
            end else begin
                run1 = 0;
            end
        end
        chk("b2b_count_lat1", 32'(cnt0), 32'd8);
        chk("b2b_run_lat2", 32'(max1), 32'd8);

        // Read-during-write across ports returns old data, then new data.
        drive(0, 1'b0, 1'b1, 7, 32'h00000002, 4'hF);
        drive(1, 1'b1, 1'b0, 7, 32'h0, 4'h0);
        tick();
        idle();
        chk("rdw_old", rdata[0][1], 32'h00000001);
        drive(1, 1'b1, 1'b0, 7, 32'h0, 4'h0);
        tick();
        idle();
        chk("rdw_new", rdata[0][1], 32'h00000002);
        repeat (2) tick();

        // Read and write together on one port: write only.
        drive(0, 1'b1, 1'b1, 8, 32'h00000077, 4'hF);
        tick();
        idle();
        chk("rw_no_read", 32'(rvalid[0][0]), 32'd0);
        repeat (3) tick();

        // reset_req stalls new commands but lets an accepted read finish.
        drive(0, 1'b1, 1'b0, 5, 32'h0, 4'h0);
        tick();
        reset_req = 1'b1;
        drive(0, 1'b1, 1'b0, 6, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 6, 32'h0, 4'h0);
        #1;
        chk("rreq_wait_s1", 32'(wreq[0][0]), 32'd1);
        chk("rreq_wait_s2", 32'(wreq[0][1]), 32'd1);
        chk("rreq_inflight_lat1", 32'(rvalid[0][0]), 32'd1);
        chk("rreq_data_lat1", rdata[0][0], 32'hDEADBEEF);
        tick();
        chk("rreq_inflight_lat2", 32'(rvalid[1][0]), 32'd1);
        repeat (2) tick();
        reset_req = 1'b0;
        idle();
        repeat (3) tick();

        // Fill memory, then reset in the middle of the clear.
        for (int a = 0; a < DEP; a++) begin
            drive(0, 1'b0, 1'b1, a, 32'hA5000000 | 32'(a), 4'hF);
            tick();
        end
        idle();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        repeat (8) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        count_wait("midclear_wait_cycles");
        for (int a = 0; a < DEP; a++) begin
            drive(0, 1'b1, 1'b0, a, 32'h0, 4'h0);
            tick();
        end
        idle();
        repeat (3) tick();
        chk("midclear_last_word", rdata[0][0], 32'h0);

        // Randomised traffic against the model.
        for (int i = 0; i < 900; i++) begin
            for (int p = 0; p < 2; p++) begin
                cs[p]   = ($urandom_range(0, 3) != 0);
                rd[p]   = 1'($urandom_range(0, 1));
                wr[p]   = 1'($urandom_range(0, 1));
                addr[p] = AW'($urandom_range(0, 19));
                be[p]   = 4'($urandom);
                wd[p]   = $urandom;
            end
            reset_req = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset     = 1'b0;
        reset_req = 1'b0;
        idle();
        repeat (25) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
